// File: rtl/compute_t_pkg.sv
// Shared definitions for the IDCT T = S' x C stage: FSM state type,
// memory base addresses, output scaling and the C coefficient magnitudes
// (also used by the later S = C^T x T stage).
package compute_t_pkg;

    typedef enum logic [2:0] {
        S_CT_IDLE      = 3'd0,
        S_CT_LOAD      = 3'd1,
        S_CT_LOAD_LAST = 3'd2,
        S_CT_MAC       = 3'd3,
        S_CT_WRITE     = 3'd4,
        S_CT_DONE      = 3'd5
    } CT_state_type;

    // DPRAM0 word address of S'[0][0] and DPRAM1 word address of T[0][0]
    localparam logic [6:0] SRC_BASE = 7'd64;
    localparam logic [6:0] DST_BASE = 7'd0;

    // Arithmetic right shift applied to each accumulated T value
    localparam int T_SHIFT = 8;

    // Bias added before the shift when round-half-up output is built in
    localparam logic signed [31:0] ROUND_BIAS = 32'sd1 <<< (T_SHIFT - 1);

    // C magnitudes named after the cosine index they scale (C_COS4 is row 0)
    localparam logic signed [15:0] C_COS1 = 16'sd2008;
    localparam logic signed [15:0] C_COS2 = 16'sd1892;
    localparam logic signed [15:0] C_COS3 = 16'sd1702;
    localparam logic signed [15:0] C_COS4 = 16'sd1448;
    localparam logic signed [15:0] C_COS5 = 16'sd1137;
    localparam logic signed [15:0] C_COS6 = 16'sd783;
    localparam logic signed [15:0] C_COS7 = 16'sd399;

endpackage

// File: rtl/compute_t_if.sv
// Handshake and DPRAM bus between the Milestone 2 controller / memories
// (master side) and the compute_t stage (slave side).
interface compute_t_if;
    logic        CT_start;
    logic        CT_done;
    logic [6:0]  CT_read_address;
    logic [31:0] CT_read_data;
    logic [6:0]  CT_write_address;
    logic [31:0] CT_write_data;
    logic        CT_write_enable;

    modport master (
        output CT_start,
        output CT_read_data,
        input  CT_done,
        input  CT_read_address,
        input  CT_write_address,
        input  CT_write_data,
        input  CT_write_enable
    );

    modport slave (
        input  CT_start,
        input  CT_read_data,
        output CT_done,
        output CT_read_address,
        output CT_write_address,
        output CT_write_data,
        output CT_write_enable
    );
endinterface

// File: rtl/compute_t_c_coeff_rom.sv
// Combinational IDCT coefficient lookup {k, col} -> signed C[k][col].
// Only columns 0..3 are tabulated: C[k][7-col] = (-1)^k * C[k][col],
// so columns 4..7 are mirrored and negated for odd k.
import compute_t_pkg::*;

module c_coeff_rom (
    input  logic [2:0]         k,
    input  logic [2:0]         col,
    output logic signed [15:0] coeff
);

    logic [1:0]         idx_s;
    logic               neg_s;
    logic [63:0]        half_row_s;
    logic signed [15:0] mag_s;

    // Fold the column into the tabulated half and pick the row entry
    always_comb begin
        idx_s = col[2] ? ~col[1:0] : col[1:0];
        neg_s = col[2] & k[0];
        // entries packed {col3, col2, col1, col0}
        case (k)
            3'd0:    half_row_s = {C_COS4,    C_COS4,    C_COS4,    C_COS4};
            3'd1:    half_row_s = {C_COS7,    C_COS5,    C_COS3,    C_COS1};
            3'd2:    half_row_s = {(-C_COS2), (-C_COS6), C_COS6,    C_COS2};
            3'd3:    half_row_s = {(-C_COS5), (-C_COS1), (-C_COS7), C_COS3};
            3'd4:    half_row_s = {C_COS4,    (-C_COS4), (-C_COS4), C_COS4};
            3'd5:    half_row_s = {C_COS3,    C_COS7,    (-C_COS1), C_COS5};
            3'd6:    half_row_s = {(-C_COS6), C_COS2,    (-C_COS2), C_COS6};
            3'd7:    half_row_s = {(-C_COS1), C_COS3,    (-C_COS5), C_COS7};
            default: half_row_s = 64'd0;
        endcase
        mag_s = $signed(half_row_s[{idx_s, 4'b0000} +: 16]);
        if (neg_s) begin
            coeff = -mag_s;
        end else begin
            coeff = mag_s;
        end
    end

endmodule

// File: rtl/compute_t.sv
// compute_t: T = S' x C for one 8x8 block.
// Loads one row of S' from DPRAM0 into sreg, then for each column runs an
// 8-step multiply-accumulate against C and writes the scaled result to DPRAM1.
// Optional build macro: CT_ROUND_EN selects round-half-up output scaling
// instead of truncation toward -inf; timing is the same either way.
import compute_t_pkg::*;

module compute_t (
    input  logic        CLOCK_50_I,
    input  logic        Reset,
    compute_t_if.slave  ct
);

    CT_state_type       state_r;
    CT_state_type       state_next_s;
    logic [2:0]         row_r;
    logic [2:0]         col_r;
    logic [2:0]         k_r;
    logic signed [31:0] acc_r;
    logic signed [31:0] sreg_r [0:7];

    logic signed [15:0] coeff_s;
    logic signed [31:0] coeff_ext_s;
    logic signed [31:0] prod_s;
    logic signed [31:0] t_val_s;

    c_coeff_rom u_c_coeff_rom (
        .k     (k_r),
        .col   (col_r),
        .coeff (coeff_s)
    );

    // 32x16 signed product kept to 32 bits; the S' and C ranges cannot overflow it
    assign coeff_ext_s = 32'(coeff_s);
    assign prod_s      = sreg_r[k_r] * coeff_ext_s;

`ifdef CT_ROUND_EN
    assign t_val_s = (acc_r + ROUND_BIAS) >>> T_SHIFT;
`else
    assign t_val_s = acc_r >>> T_SHIFT;
`endif

    // State register
    always_ff @(posedge CLOCK_50_I) begin
        if (Reset) begin
            state_r <= S_CT_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_CT_IDLE: begin
                if (ct.CT_start) begin
                    state_next_s = S_CT_LOAD;
                end else begin
                    state_next_s = S_CT_IDLE;
                end
            end
            S_CT_LOAD: begin
                if (k_r == 3'd7) begin
                    state_next_s = S_CT_LOAD_LAST;
                end else begin
                    state_next_s = S_CT_LOAD;
                end
            end
            S_CT_LOAD_LAST: state_next_s = S_CT_MAC;
            S_CT_MAC: begin
                if (k_r == 3'd7) begin
                    state_next_s = S_CT_WRITE;
                end else begin
                    state_next_s = S_CT_MAC;
                end
            end
            S_CT_WRITE: begin
                if (col_r != 3'd7) begin
                    state_next_s = S_CT_MAC;
                end else if (row_r != 3'd7) begin
                    state_next_s = S_CT_LOAD;
                end else begin
                    state_next_s = S_CT_DONE;
                end
            end
            S_CT_DONE: state_next_s = S_CT_IDLE;
            default:   state_next_s = S_CT_IDLE;
        endcase
    end

    // Output decode from registered state and counters
    always_comb begin
        ct.CT_read_address  = 7'd0;
        ct.CT_write_address = 7'd0;
        ct.CT_write_data    = 32'd0;
        ct.CT_write_enable  = 1'b0;
        ct.CT_done          = 1'b0;
        case (state_r)
            S_CT_LOAD: begin
                ct.CT_read_address = SRC_BASE + 7'({row_r, k_r});
            end
            S_CT_WRITE: begin
                ct.CT_write_enable  = 1'b1;
                ct.CT_write_address = DST_BASE + 7'({row_r, col_r});
                ct.CT_write_data    = t_val_s;
            end
            S_CT_DONE: begin
                ct.CT_done = 1'b1;
            end
            default: begin
                ct.CT_done = 1'b0;
            end
        endcase
    end

    // Counters, row buffer and accumulator
    always_ff @(posedge CLOCK_50_I) begin
        if (Reset) begin
            row_r <= 3'd0;
            col_r <= 3'd0;
            k_r   <= 3'd0;
            acc_r <= 32'sd0;
            for (int i = 0; i < 8; i++) begin
                sreg_r[i] <= 32'sd0;
            end
        end else begin
            case (state_r)
                S_CT_IDLE: begin
                    if (ct.CT_start) begin
                        row_r <= 3'd0;
                        k_r   <= 3'd0;
                    end
                end
                S_CT_LOAD: begin
                    k_r <= k_r + 3'd1;
                    // read data lags the address by one cycle, so it belongs to k-1
                    if (k_r != 3'd0) begin
                        sreg_r[k_r - 3'd1] <= ct.CT_read_data;
                    end
                end
                S_CT_LOAD_LAST: begin
                    sreg_r[7] <= ct.CT_read_data;
                    col_r     <= 3'd0;
                    k_r       <= 3'd0;
                    acc_r     <= 32'sd0;
                end
                S_CT_MAC: begin
                    acc_r <= acc_r + prod_s;
                    k_r   <= k_r + 3'd1;
                end
                S_CT_WRITE: begin
                    acc_r <= 32'sd0;
                    if (col_r != 3'd7) begin
                        col_r <= col_r + 3'd1;
                    end else begin
                        col_r <= 3'd0;
                        k_r   <= 3'd0;
                        if (row_r != 3'd7) begin
                            row_r <= row_r + 3'd1;
                        end
                    end
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_compute_t.sv
// Self-checking bench for compute_t: DPRAM0/DPRAM1 models, table-driven
// single-coefficient vectors, random blocks against a matrix-product model,
// and hand-written sequences for start-while-busy and mid-block reset.
module tb_compute_t;

    localparam real PI = 3.14159265358979;

    logic clk = 1'b0;
    logic rst;
    always #10 clk = ~clk;

    compute_t_if ct_bus();

    compute_t dut (
        .CLOCK_50_I (clk),
        .Reset      (rst),
        .ct         (ct_bus)
    );

    logic [31:0] mem0 [128];
    logic [31:0] mem1 [64];
    int wr_stamp [64] = '{default: 0};
    int wr_total   = 0;
    int done_total = 0;
    int oob_total  = 0;

    int total = 0;
    int bad   = 0;
    int cm    [8][8];
    int sp    [8][8];
    int exp_t [64];

    typedef struct {
        int r;
        int c;
        int v;
        int row_exp [8];
    } vec_t;
    vec_t vecs [4];

    // DPRAM0: registered read, data one cycle after the address
    always @(posedge clk) ct_bus.CT_read_data <= mem0[ct_bus.CT_read_address];

    // DPRAM1 and event monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (ct_bus.CT_write_enable) begin
            wr_total <= wr_total + 1;
            if (ct_bus.CT_write_address < 7'd64) begin
                mem1[ct_bus.CT_write_address[5:0]]     <= ct_bus.CT_write_data;
                wr_stamp[ct_bus.CT_write_address[5:0]] <= wr_total + 1;
            end else begin
                oob_total <= oob_total + 1;
            end
        end
        if (ct_bus.CT_done) done_total <= done_total + 1;
    end

    task automatic chk(input string name, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // C from its definition; the tabulated magnitudes are the truncated products
    function automatic int c_model(input int k, input int c);
        real a, v, m;
        a = (k == 0) ? $sqrt(0.125) : 0.5;
        v = 4096.0 * a * $cos(real'((2 * c + 1) * k) * PI / 16.0);
        m = $floor((v < 0.0) ? -v : v);
        return (v < 0.0) ? -int'(m) : int'(m);
    endfunction

    task automatic clear_sp();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                sp[r][c] = 0;
    endtask

    task automatic random_sp();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                sp[r][c] = int'($urandom_range(0, 65535)) - 32768;
    endtask

    // Upper half of DPRAM0 gets S', lower half gets noise the DUT must not read
    task automatic load_mem0();
        for (int i = 0; i < 64; i++) mem0[i] = $urandom;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                mem0[64 + 8 * r + c] = 32'(sp[r][c]);
    endtask

    // Reference T = (S' x C) scaled
    task automatic model_t();
        longint acc;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                acc = 0;
                for (int k = 0; k < 8; k++) acc += longint'(sp[r][k]) * longint'(cm[k][c]);
`ifdef CT_ROUND_EN
                acc += 128;
`endif
                acc = acc >>> 8;
                exp_t[8 * r + c] = int'(acc);
            end
    endtask

    // Start one block; pulse CT_start again at cycles p1/p2; lat=-1 on timeout
    task automatic run_block(input int p1, input int p2, output int lat);
        lat = -1;
        @(negedge clk);
        ct_bus.CT_start = 1'b1;
        @(negedge clk);
        ct_bus.CT_start = 1'b0;
        for (int n = 1; n <= 900 && lat < 0; n++) begin
            if (ct_bus.CT_done) lat = n;
            ct_bus.CT_start = (n == p1) || (n == p2);
            @(negedge clk);
        end
        ct_bus.CT_start = 1'b0;
        repeat (30) @(negedge clk);
    endtask

    task automatic check_block(input string tag, input int snap);
        longint got;
        for (int i = 0; i < 64; i++) begin
            got = longint'($signed(mem1[i]));
            total++;
            if (wr_stamp[i] <= snap || got != longint'(exp_t[i])) begin
                bad++;
                $display("FAIL %s T[%0d][%0d]: got %0d (written=%0d), want %0d",
                         tag, i / 8, i % 8, got, wr_stamp[i] > snap, exp_t[i]);
            end
        end
    endtask

    task automatic run_and_check(input string tag, input int p1, input int p2);
        int snap, dsnap, lat;
        snap  = wr_total;
        dsnap = done_total;
        load_mem0();
        run_block(p1, p2, lat);
        chk({tag, " latency"}, lat, 649);
        chk({tag, " writes"}, wr_total - snap, 64);
        chk({tag, " done pulses"}, done_total - dsnap, 1);
        check_block(tag, snap);
    endtask

    initial begin
        int snap, dsnap;
        rst = 1'b1;
        ct_bus.CT_start = 1'b0;
        for (int i = 0; i < 128; i++) mem0[i] = 32'd0;
        for (int k = 0; k < 8; k++)
            for (int c = 0; c < 8; c++)
                cm[k][c] = c_model(k, c);

        vecs[0].r = 0; vecs[0].c = 0; vecs[0].v = -256;
        vecs[0].row_exp = '{-1448, -1448, -1448, -1448, -1448, -1448, -1448, -1448};
        vecs[1].r = 0; vecs[1].c = 0; vecs[1].v = 1;
`ifdef CT_ROUND_EN
        vecs[1].row_exp = '{6, 6, 6, 6, 6, 6, 6, 6};
`else
        vecs[1].row_exp = '{5, 5, 5, 5, 5, 5, 5, 5};
`endif
        vecs[2].r = 0; vecs[2].c = 1; vecs[2].v = 256;
        vecs[2].row_exp = '{2008, 1702, 1137, 399, -399, -1137, -1702, -2008};
        vecs[3].r = 5; vecs[3].c = 3; vecs[3].v = 256;
        vecs[3].row_exp = '{1702, -399, -2008, -1137, 1137, 2008, 399, -1702};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset done", ct_bus.CT_done, 0);
        chk("reset we", ct_bus.CT_write_enable, 0);
        chk("reset waddr", ct_bus.CT_write_address, 0);
        chk("reset wdata", ct_bus.CT_write_data, 0);
        chk("reset raddr", ct_bus.CT_read_address, 0);
        rst = 1'b0;
        @(negedge clk);

        // DC column in every row -> every T is 1448
        clear_sp();
        for (int r = 0; r < 8; r++) sp[r][0] = 256;
        for (int i = 0; i < 64; i++) exp_t[i] = 1448;
        run_and_check("dc_col", 0, 0);

        // Single-coefficient table
        for (int v = 0; v < 4; v++) begin
            clear_sp();
            sp[vecs[v].r][vecs[v].c] = vecs[v].v;
            for (int i = 0; i < 64; i++) exp_t[i] = 0;
            for (int c = 0; c < 8; c++) exp_t[8 * vecs[v].r + c] = vecs[v].row_exp[c];
            run_and_check($sformatf("vec%0d", v), 0, 0);
        end

        // Random blocks against the reference model
        for (int b = 0; b < 3; b++) begin
            random_sp();
            model_t();
            run_and_check($sformatf("rand%0d", b), 0, 0);
        end

        // Start while busy, and start coinciding with CT_done
        random_sp();
        model_t();
        run_and_check("busy_start", 10, 300);
        random_sp();
        model_t();
        run_and_check("start_at_done", 649, 0);

        // Reset in the middle of a block
        random_sp();
        model_t();
        load_mem0();
        dsnap = done_total;
        @(negedge clk);
        ct_bus.CT_start = 1'b1;
        @(negedge clk);
        ct_bus.CT_start = 1'b0;
        repeat (199) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst we", ct_bus.CT_write_enable, 0);
        chk("midrst waddr", ct_bus.CT_write_address, 0);
        chk("midrst wdata", ct_bus.CT_write_data, 0);
        chk("midrst raddr", ct_bus.CT_read_address, 0);
        chk("midrst done", ct_bus.CT_done, 0);
        snap = wr_total;
        rst = 1'b0;
        repeat (700) @(negedge clk);
        chk("midrst no writes", wr_total - snap, 0);
        chk("midrst no done", done_total - dsnap, 0);
        run_and_check("after_rst", 0, 0);

        chk("out-of-range writes", oob_total, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
